// File: rtl/counter_chain_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// counter_seq_pkg
// Shared definitions for the counter chain run sequencer:
//   - seq_state_t : run-controller state, explicit 3-bit encoding
//   - STATE_W     : width of the state encoding
//   - CLEAR_CYCLES_DEFAULT : default number of cycles chain_clr is held
// -----------------------------------------------------------------------------
package counter_seq_pkg;

    localparam int STATE_W              = 3;
    localparam int CLEAR_CYCLES_DEFAULT = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/counter_chain_sequencer_if.sv
// -----------------------------------------------------------------------------
// counter_chain_sequencer_if
// Host-side bundle of the counter chain sequencer.
//   start        : run request (host -> sequencer)
//   run_len      : number of enabled chain cycles, latched with start
//   abort        : synchronous abort
//   result_ready : host accepts result/cycles_run
//   busy         : sequencer not idle
//   err_len      : one-cycle pulse, start seen with run_len == 0
//   result       : captured chain count
//   cycles_run   : number of cycles the chain was actually enabled
//   result_valid : result/cycles_run valid
// Optional (macro SEQ_PAUSE_EN):
//   pause        : freeze the chain while running
//   pause_cycles : saturating count of paused run cycles
// Modports: master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface counter_chain_sequencer_if #(
    parameter int COUNT_W = 16,
    parameter int RUN_W   = 32
);

    logic               start;
    logic [RUN_W-1:0]   run_len;
    logic               abort;
    logic               result_ready;
    logic               busy;
    logic               err_len;
    logic [COUNT_W-1:0] result;
    logic [RUN_W-1:0]   cycles_run;
    logic               result_valid;
`ifdef SEQ_PAUSE_EN
    logic               pause;
    logic [RUN_W-1:0]   pause_cycles;
`endif

    modport master (
        output start,
        output run_len,
        output abort,
        output result_ready,
        input  busy,
        input  err_len,
        input  result,
        input  cycles_run,
        input  result_valid
`ifdef SEQ_PAUSE_EN
        ,
        output pause,
        input  pause_cycles
`endif
    );

    modport slave (
        input  start,
        input  run_len,
        input  abort,
        input  result_ready,
        output busy,
        output err_len,
        output result,
        output cycles_run,
        output result_valid
`ifdef SEQ_PAUSE_EN
        ,
        input  pause,
        output pause_cycles
`endif
    );

endinterface

// File: rtl/counter_chain_sequencer_down_counter.sv
// -----------------------------------------------------------------------------
// seq_down_counter
// Loadable down-counter with enable and zero flag. Load has priority over
// decrement; the count holds at zero instead of wrapping.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset (count -> 0)
//   load     : load load_val this edge
//   load_val : value to load
//   en       : decrement this edge
//   count    : current count
//   zero     : count == 0
// -----------------------------------------------------------------------------
module seq_down_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/counter_chain_sequencer.sv
// -----------------------------------------------------------------------------
// counter_chain_sequencer
// Run controller for a chained counter datapath. A start request clears the
// chain for CLEAR_CYCLES cycles, enables it for exactly run_len cycles, then
// snapshots the last-stage count and offers it on a valid/ready handshake.
//
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   host        : counter_chain_sequencer_if.slave (start/run_len/abort,
//                 busy/err_len, result/cycles_run/result_valid/result_ready)
//   chain_clr   : synchronous clear to the counter chain
//   chain_en    : count enable to the first chain stage
//   chain_count : last-stage count from the chain
//
// Optional feature, macro SEQ_PAUSE_EN: host.pause freezes the run (chain_en
// low, remaining/elapsed held) and host.pause_cycles counts paused cycles.
// -----------------------------------------------------------------------------
module counter_chain_sequencer
    import counter_seq_pkg::*;
#(
    parameter int COUNT_W      = 16,
    parameter int RUN_W        = 32,
    parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    counter_chain_sequencer_if.slave host,
    output logic                chain_clr,
    output logic                chain_en,
    input  logic [COUNT_W-1:0]  chain_count
);

    seq_state_t       state;
    logic [RUN_W-1:0] run_len_q;
    logic [RUN_W-1:0] elapsed;

    logic             cnt_load;
    logic [RUN_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic [RUN_W-1:0] cnt_count;
    logic             cnt_zero;
    logic             run_last;
    logic             pause_now;

`ifdef SEQ_PAUSE_EN
    assign pause_now = host.pause;
`else
    assign pause_now = 1'b0;
`endif

    // One counter times the clear phase and then holds the remaining enabled
    // cycles of the run phase.
    seq_down_counter #(
        .W (RUN_W)
    ) u_down (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    // The enabled cycle now in progress is the last one of the run.
    assign run_last = chain_en && (cnt_count == RUN_W'(1));

    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        if (!host.abort) begin
            case (state)
                IDLE: begin
                    if (host.start && (host.run_len != '0)) begin
                        // Loaded with N-1 so the zero flag marks the final clear cycle.
                        cnt_load     = 1'b1;
                        cnt_load_val = RUN_W'(CLEAR_CYCLES - 1);
                    end
                end
                CLEAR: begin
                    if (cnt_zero) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = run_len_q;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                RUN: begin
                    // Only cycles in which the chain was really enabled count down.
                    cnt_en = chain_en;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            run_len_q         <= '0;
            elapsed           <= '0;
            chain_clr         <= 1'b0;
            chain_en          <= 1'b0;
            host.busy         <= 1'b0;
            host.err_len      <= 1'b0;
            host.result       <= '0;
            host.cycles_run   <= '0;
            host.result_valid <= 1'b0;
`ifdef SEQ_PAUSE_EN
            host.pause_cycles <= '0;
`endif
        end else begin
            host.err_len <= 1'b0;
            if (host.abort) begin
                // Abort beats every transition, including a start in IDLE;
                // the captured result registers are left untouched.
                state             <= IDLE;
                chain_clr         <= 1'b0;
                chain_en          <= 1'b0;
                host.busy         <= 1'b0;
                host.result_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (host.start) begin
                            if (host.run_len != '0) begin
                                state     <= CLEAR;
                                run_len_q <= host.run_len;
                                elapsed   <= '0;
                                chain_clr <= 1'b1;
                                host.busy <= 1'b1;
`ifdef SEQ_PAUSE_EN
                                host.pause_cycles <= '0;
`endif
                            end else begin
                                host.err_len <= 1'b1;
                            end
                        end
                    end
                    CLEAR: begin
                        if (cnt_zero) begin
                            state     <= RUN;
                            chain_clr <= 1'b0;
                            chain_en  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (chain_en) begin
                            elapsed <= elapsed + RUN_W'(1);
                        end
                        if (run_last) begin
                            // chain_en falls on the same edge remaining hits zero.
                            state    <= CAPTURE;
                            chain_en <= 1'b0;
                        end else begin
                            chain_en <= !pause_now;
`ifdef SEQ_PAUSE_EN
                            if (pause_now && (host.pause_cycles != '1)) begin
                                host.pause_cycles <= host.pause_cycles + RUN_W'(1);
                            end
`endif
                        end
                    end
                    CAPTURE: begin
                        // The chain took its last enable on the previous edge,
                        // so chain_count is final here.
                        state             <= DONE;
                        host.result       <= chain_count;
                        host.cycles_run   <= elapsed;
                        host.result_valid <= 1'b1;
                    end
                    DONE: begin
                        if (host.result_ready) begin
                            state             <= IDLE;
                            host.busy         <= 1'b0;
                            host.result_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state             <= IDLE;
                        chain_clr         <= 1'b0;
                        chain_en          <= 1'b0;
                        host.busy         <= 1'b0;
                        host.result_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_chain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_chain_sequencer
// Bench for counter_chain_sequencer: a simple counter chain, a timeline-based
// reference model of the sequencer, per-cycle comparison, directed scenarios
// and a randomized phase. Build with SEQ_PAUSE_EN to include the pause feature.
// -----------------------------------------------------------------------------
module tb_counter_chain_sequencer;

    localparam int COUNT_W = 16;
    localparam int RUN_W   = 32;
    localparam int CC      = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               chain_clr;
    logic               chain_en;
    logic [COUNT_W-1:0] chain_count = 16'hA5A5;

    counter_chain_sequencer_if #(.COUNT_W(COUNT_W), .RUN_W(RUN_W)) host ();

    counter_chain_sequencer #(
        .COUNT_W      (COUNT_W),
        .RUN_W        (RUN_W),
        .CLEAR_CYCLES (CC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host        (host),
        .chain_clr   (chain_clr),
        .chain_en    (chain_en),
        .chain_count (chain_count)
    );

    always #5 clk = ~clk;

    // Counter chain under control: synchronous clear, increments when enabled.
    always @(posedge clk) begin
        if (chain_clr) chain_count <= '0;
        else if (chain_en) chain_count <= chain_count + 16'd1;
    end

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (timeline of one run) ----------------
    int  cyc = 0;
    bit  act = 1'b0;
    int  e0, run_l, en_given, cap_k, k;
    bit  hs, paused, pz;
    bit  ex_clr = 0, ex_en = 0, ex_valid = 0, ex_err = 0, ex_busy = 0;
    logic [COUNT_W-1:0] ex_result = '0;
    logic [RUN_W-1:0]   ex_cycles = '0;
    logic [RUN_W-1:0]   ex_pc = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            act = 0; ex_clr = 0; ex_en = 0; ex_valid = 0; ex_err = 0; ex_busy = 0;
            ex_result = '0; ex_cycles = '0; ex_pc = '0;
        end else begin
            cyc++;
`ifdef SEQ_PAUSE_EN
            pz = host.pause;
`else
            pz = 1'b0;
`endif
            if (ex_en) en_given++;
            hs = ex_valid && host.result_ready;
            ex_err = 0;
            if (host.abort) begin
                act = 0; ex_clr = 0; ex_en = 0; ex_valid = 0;
            end else if (!act) begin
                ex_clr = 0; ex_en = 0; ex_valid = 0;
                if (host.start) begin
                    if (host.run_len == 0) ex_err = 1;
                    else begin
                        act = 1; e0 = cyc; run_l = int'(host.run_len);
                        en_given = 0; cap_k = -1; ex_pc = '0;
                        ex_clr = 1;
                    end
                end
            end else if (hs) begin
                act = 0; ex_valid = 0;
            end else begin
                k = cyc - e0 + 1;                 // index of the coming cycle
                ex_clr = (k <= CC);
                paused = pz && (k - 1 > CC) && (en_given < run_l);
                ex_en = (k > CC) && (en_given < run_l) && !paused;
                if (paused) ex_pc++;
                if (en_given == run_l && cap_k < 0) cap_k = k;
                if (cap_k >= 0 && k == cap_k + 1) begin
                    ex_result = run_l[COUNT_W-1:0];
                    ex_cycles = RUN_W'(run_l);
                    ex_valid = 1;
                end
            end
            ex_busy = act;
        end
    end

    // ---------------- per-cycle compare + statistics ----------------
    int n_clr, n_en, last_en, first_valid;
    bit saw_valid;

    task automatic clear_stats();
        n_clr = 0; n_en = 0; last_en = -100; first_valid = -1; saw_valid = 0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 64'(host.busy), 64'(ex_busy));
            chk("err_len", 64'(host.err_len), 64'(ex_err));
            chk("chain_clr", 64'(chain_clr), 64'(ex_clr));
            chk("chain_en", 64'(chain_en), 64'(ex_en));
            chk("result_valid", 64'(host.result_valid), 64'(ex_valid));
            chk("result", 64'(host.result), 64'(ex_result));
            chk("cycles_run", 64'(host.cycles_run), 64'(ex_cycles));
`ifdef SEQ_PAUSE_EN
            chk("pause_cycles", 64'(host.pause_cycles), 64'(ex_pc));
`endif
        end
        if (chain_clr) n_clr++;
        if (chain_en) begin n_en++; last_en = cyc; end
        if (host.result_valid) begin
            saw_valid = 1;
            if (first_valid < 0) first_valid = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic do_start(input logic [RUN_W-1:0] len);
        host.start = 1'b1; host.run_len = len;
        step();
        host.start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (host.result_valid) ok = 1;
        end
        if (!ok) chk("result_valid timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_en(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (chain_en) ok = 1;
        end
        if (!ok) chk("chain_en timeout", 64'd0, 64'd1);
    endtask

    task automatic handshake();
        host.result_ready = 1'b1;
        step();
        host.result_ready = 1'b0;
    endtask

    initial begin
        host.start = 0; host.run_len = '0; host.abort = 0; host.result_ready = 0;
`ifdef SEQ_PAUSE_EN
        host.pause = 0;
`endif
        clear_stats();
        #1 reset = 1'b0;
        #1 chk_on = 1'b1;
        repeat (3) step();
        chk("reset busy", 64'(host.busy), 64'd0);
        chk("reset result", 64'(host.result), 64'd0);
        chk("reset cycles_run", 64'(host.cycles_run), 64'd0);
        chk("reset chain_en", 64'(chain_en), 64'd0);
        reset = 1'b1;
        step();

        // Run of 10 with the consumer stalled until the result shows up.
        clear_stats();
        do_start(32'd10);
        wait_valid(60);
        chk("run10 result", 64'(host.result), 64'd10);
        chk("run10 cycles_run", 64'(host.cycles_run), 64'd10);
        chk("run10 clr cycles", 64'(n_clr), 64'd2);
        chk("run10 en cycles", 64'(n_en), 64'd10);
        chk("run10 valid latency", 64'(first_valid - last_en), 64'd2);
        handshake();
        chk("run10 idle after hs", 64'(host.busy), 64'd0);

        // Zero-length request.
        clear_stats();
        do_start(32'd0);
        chk("len0 err_len", 64'(host.err_len), 64'd1);
        chk("len0 busy", 64'(host.busy), 64'd0);
        step();
        chk("len0 err_len pulse", 64'(host.err_len), 64'd0);
        repeat (5) step();
        chk("len0 no enable", 64'(n_en), 64'd0);

        // Long stall in DONE, second start ignored.
        clear_stats();
        do_start(32'd5);
        wait_valid(40);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin host.start = 1; host.run_len = 32'd7; end
            else host.start = 0;
            step();
        end
        chk("stall valid held", 64'(host.result_valid), 64'd1);
        chk("stall result", 64'(host.result), 64'd5);
        handshake();
        chk("stall idle after hs", 64'(host.busy), 64'd0);
        chk("stall result kept", 64'(host.result), 64'd5);

        // Abort in the third run cycle.
        clear_stats();
        do_start(32'd100);
        wait_en(20);
        step();
        step();
        host.abort = 1'b1;
        step();
        host.abort = 1'b0;
        chk("abort chain_en", 64'(chain_en), 64'd0);
        chk("abort busy", 64'(host.busy), 64'd0);
        repeat (120) step();
        chk("abort no result", 64'(saw_valid), 64'd0);
        chk("abort result kept", 64'(host.result), 64'd5);

        // Asynchronous reset in the middle of a run.
        clear_stats();
        do_start(32'd50);
        wait_en(20);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("async rst chain_en", 64'(chain_en), 64'd0);
        chk("async rst busy", 64'(host.busy), 64'd0);
        repeat (3) step();
        reset = 1'b1;
        step();
        clear_stats();
        host.result_ready = 1'b1;
        do_start(32'd4);
        wait_valid(30);
        chk("post rst result", 64'(host.result), 64'd4);
        chk("post rst cycles_run", 64'(host.cycles_run), 64'd4);
        step();
        host.result_ready = 1'b0;

`ifdef SEQ_PAUSE_EN
        // Pause for three cycles in the middle of an 8-cycle run.
        clear_stats();
        do_start(32'd8);
        wait_en(20);
        step();
        step();
        host.pause = 1'b1;
        repeat (3) step();
        host.pause = 1'b0;
        wait_valid(40);
        chk("pause cycles_run", 64'(host.cycles_run), 64'd8);
        chk("pause pause_cycles", 64'(host.pause_cycles), 64'd3);
        chk("pause en cycles", 64'(n_en), 64'd8);
        handshake();
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            host.start = ($urandom_range(0, 3) == 0);
            host.run_len = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
            host.abort = ($urandom_range(0, 59) == 0);
            host.result_ready = 1'($urandom_range(0, 1));
`ifdef SEQ_PAUSE_EN
            host.pause = ($urandom_range(0, 3) == 0);
`endif
            step();
        end
        host.start = 0; host.abort = 0; host.result_ready = 0;
`ifdef SEQ_PAUSE_EN
        host.pause = 0;
`endif
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_chain_sequencer.md
Name: counter_chain_sequencer

Overview:
Run controller for a chained N-bit counter datapath (global enable, synchronous clear, last-stage count output).
- On a start request it clears the chain and enables it for exactly a programmed number of clock cycles.
- It then snapshots the chain's output count and presents it with a valid/ready handshake.
- It sits between a host/test harness and the counter chain, making chain runs deterministic and measurable.

Parameters:
- COUNT_W, 16, width of chain count input and result output.
- RUN_W, 32, width of run-length and elapsed-cycle counters.
- CLEAR_CYCLES, 2, number of cycles chain_clr is held (≥1).

Ports:
- clk, input, 1, single system clock, rising edge.
- reset, input, 1, asynchronous active-low reset; 0 resets all state immediately.
- start, input, 1, run request; sampled only in IDLE.
- run_len, input, RUN_W, enabled-cycle count; latched with start.
- abort, input, 1, synchronous abort from any state.
- busy, output, 1, high in every state except IDLE.
- err_len, output, 1, one-cycle pulse when start is seen with run_len==0.
- chain_clr, output, 1, synchronous clear to the counter chain.
- chain_en, output, 1, count enable to the first counter of the chain.
- chain_count, input, COUNT_W, last-stage count from the chain.
- result, output, COUNT_W, captured chain_count.
- cycles_run, output, RUN_W, number of cycles chain_en was actually high.
- result_valid, output, 1, result/cycles_run valid.
- result_ready, input, 1, consumer accepts result.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, err_len, chain_clr, chain_en, result_valid all 0; result and cycles_run are 0.
- All outputs are registered.
- States:
  - IDLE→CLEAR on start && run_len!=0: latch run_len into remaining; elapsed=0.
  - start && run_len==0: err_len=1 for one cycle; stay IDLE.
  - CLEAR: chain_clr=1 for exactly CLEAR_CYCLES cycles, chain_en=0, then RUN.
  - RUN: chain_en=1 for exactly run_len consecutive cycles; per enabled cycle, remaining--, elapsed++. Leaving RUN, chain_en drops the same edge remaining reaches 0.
  - CAPTURE (1 cycle): chain_en=0; chain_count now holds the final value; register result<=chain_count, cycles_run<=elapsed.
  - DONE: result_valid=1, held with stable result/cycles_run until result_valid&&result_ready; then IDLE, result_valid=0 (result/cycles_run retained).
- Latency: start sampled at edge 0 → chain_clr high in cycles 1..CLEAR_CYCLES, chain_en high in the next run_len cycles, result_valid first high 2 cycles after the last chain_en cycle.
- start while busy: ignored; no err_len.
- abort (any state, priority over all transitions): next cycle state=IDLE, chain_en=0, chain_clr=0, result_valid=0; result/cycles_run not updated.
- abort and start in the same IDLE cycle: abort wins; no run.
- result_ready while result_valid=0: ignored. result_ready already high on DONE entry: handshake completes in the first DONE cycle.
- run_len = 2^RUN_W−1 is legal; elapsed never wraps.
- result is raw chain_count; chain wrap-around is not detected.
- Asynchronous reset mid-RUN: chain_en drops immediately; no result is produced.

Optional Feature:
Macro SEQ_PAUSE_EN.
- Defined: adds input pause (1) and output pause_cycles (RUN_W, saturating at all-ones).
- In RUN with pause=1: chain_en=0, remaining and elapsed frozen, pause_cycles++.
- RUN exits only after run_len enabled cycles, so cycles_run==run_len still holds.
- pause_cycles is cleared on entry to CLEAR.
- pause is ignored outside RUN.
- Undefined: neither port exists; RUN is uninterrupted.

Decomposition:
- Package counter_seq_pkg: state typedef enum {IDLE, CLEAR, RUN, CAPTURE, DONE}, its 3-bit encoding, CLEAR_CYCLES default constant.
- One sub-module seq_down_counter: loadable RUN_W down-counter with enable and zero flag. It is reused for CLEAR timing and RUN remaining count.
- The FSM and capture registers stay in the top module.

Test Plan:
- Reset, then start with run_len=10, CLEAR_CYCLES=2 → chain_clr high 2 cycles, chain_en high exactly 10 cycles, result==chain model value 10, cycles_run==10, result_valid 2 cycles after last enable.
- start with run_len=0 → err_len single-cycle pulse; busy stays 0; chain_en never asserts.
- run_len=5, result_ready held low 20 cycles then pulsed → result_valid and result stable throughout; IDLE the cycle after handshake; second start during DONE ignored.
- abort in the 3rd RUN cycle of run_len=100 → chain_en low the next cycle, result_valid never asserts, busy=0 next cycle.
- reset driven low mid-RUN, asynchronously between edges → chain_en and busy drop without a clock edge; after release, a new start with run_len=4 completes normally.
- SEQ_PAUSE_EN defined: run_len=8, pause high 3 cycles mid-run → chain_en high 8 total cycles, cycles_run==8, pause_cycles==3.
